pmem_line_arbiter: RTL and testbench
====================================

Name: pmem_line_arbiter

Overview:
- Shares the single 256-bit physical-memory line port between the instruction cache (read-only) and the data cache (read and write-back).
- The data-cache write-back path carries lines built by the byte-enable write-merge stage.
- Sits between the two cache controllers and the memory/L2 interface.
- Serves one transaction at a time, with round-robin priority on contention.
- Latches the granted address and write data so the memory side sees stable values for the whole transaction.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cache line width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_pmem_read  in  1  I-cache line read request.
- i_pmem_address  in  ADDR_W  I-cache line address; bits [4:0] are ignored.
- i_pmem_rdata  out  LINE_W  line returned to the I-cache.
- i_pmem_resp  out  1  I-cache transaction complete.
- d_pmem_read  in  1  D-cache line read request.
- d_pmem_write  in  1  D-cache line write-back request.
- d_pmem_address  in  ADDR_W  D-cache line address.
- d_pmem_wdata  in  LINE_W  D-cache write-back line.
- d_pmem_rdata  out  LINE_W  line returned to the D-cache.
- d_pmem_resp  out  1  D-cache transaction complete.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_address  out  ADDR_W  memory line address, low 5 bits forced to 0.
- pmem_wdata  out  LINE_W  memory write line.
- pmem_rdata  in  LINE_W  memory read line.
- pmem_resp  in  1  memory transaction complete.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, last_served=I (so the D-cache wins the first contention). pmem_read, pmem_write, i_pmem_resp and d_pmem_resp are 0. Address and wdata latches are 0.
- States:
  - IDLE: memory strobes are 0.
  - SERVE_I: pmem_read=1, pmem_write=0.
  - SERVE_D_RD: pmem_read=1, pmem_write=0.
  - SERVE_D_WR: pmem_read=0, pmem_write=1.
  - The strobes are registered outputs decoded from the state register.
- IDLE transitions, evaluated each cycle:
  - Only I requesting -> SERVE_I.
  - Only D requesting -> SERVE_D_WR if d_pmem_write, else SERVE_D_RD.
  - Both requesting -> serve the requester that is not last_served.
  - Neither -> stay in IDLE.
- On the IDLE->SERVE transition, latch the winner's address (with [4:0] cleared) and d_pmem_wdata.
  - pmem_address and pmem_wdata come from these latches only; later changes on the requester inputs are ignored until the next grant.
- D-cache asserting read and write together is illegal; it is treated as a write.
- Latency: grant registered one cycle after the request is seen in IDLE. Strobes assert in the first SERVE cycle.
- Completion: in SERVE_x with pmem_resp=1:
  - The matching requester's resp is asserted combinationally in that same cycle. The other requester's resp stays 0.
  - Next state is IDLE; last_served is updated to the served requester.
- Read data: pmem_rdata is broadcast combinationally to both i_pmem_rdata and d_pmem_rdata. It is valid only when the corresponding resp=1.
- Requester rule: a requester holds its request, address and wdata until it sees resp. It deasserts the request in the cycle after resp. Consequences:
  - The IDLE cycle after completion is a mandatory turnaround; back-to-back grants are separated by at least one IDLE cycle.
  - The minimum transaction is 3 cycles: grant, strobe with resp, IDLE.
- pmem_resp while in IDLE is ignored; no resp is forwarded and the state is unchanged.
- Request dropped mid-transaction (protocol violation): the transaction still completes and resp is still pulsed.
- Reset asserted mid-transaction: strobes and resps drop immediately (asynchronously). The in-flight transaction is abandoned with no resp forwarded after release.
- Starvation: with both requesters saturating, grants alternate strictly I, D, I, D...

Decomposition:
- Package arb_types:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR}.
  - requester_t enum {REQ_I, REQ_D}.
  - LINE_OFFSET_BITS=5 constant.
- Single flat module. The round-robin pick is a few gates and does not warrant a sub-module.

Test Plan:
- I-read alone: i_pmem_read=1, addr 0x0000_1234; pmem_resp 3 cycles after the strobe with rdata 0xA5..A5.
  -> pmem_address=0x0000_1220, pmem_read=1 from cycle 1.
  -> i_pmem_resp=1 exactly one cycle, i_pmem_rdata=0xA5..A5, d_pmem_resp stays 0.
- D-write alone: wdata pattern 0x0123...EF, addr 0x8000_0040.
  -> pmem_write=1, pmem_wdata equals the latched pattern even if the input changes mid-transaction.
  -> d_pmem_resp pulses once.
- Simultaneous requests out of reset, both held and re-requested after each resp.
  -> Grant order D, I, D, I.
  -> Each pair of grants separated by at least one IDLE cycle.
- D asserts read and write together.
  -> Served as SERVE_D_WR: pmem_write=1, pmem_read=0.
- Spurious pmem_resp in IDLE.
  -> No resp forwarded; state stays IDLE.
- rst_n pulsed low during SERVE_I.
  -> pmem_read drops in the same cycle; no i_pmem_resp after release.
  -> The next contention is won by D.

Source files
------------

// File: rtl/pmem_line_arbiter_pkg.sv
// Shared types for the physical-memory line arbiter: FSM states, requester
// identity and the line-offset geometry.
package arb_types;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_I    = 2'd1,
        SERVE_D_RD = 2'd2,
        SERVE_D_WR = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    localparam int LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/pmem_line_arbiter.sv
// Round-robin arbiter sharing one physical-memory line port between the
// I-cache (read-only) and the D-cache (read and write-back).
module pmem_line_arbiter
    import arb_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W-LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

    arb_state_t        state_q, state_d;
    requester_t        last_served_q, last_served_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              read_q, read_d;
    logic              write_q, write_d;

    logic              i_req_s;
    logic              d_req_s;
    logic              grant_i_s;
    logic              i_resp_s;
    logic              d_resp_s;

    assign i_req_s   = i_pmem_read;
    assign d_req_s   = d_pmem_read | d_pmem_write;
    // On contention the requester that was not served last wins.
    assign grant_i_s = i_req_s & (~d_req_s | (last_served_q == REQ_D));

    // Next-state, grant latching and completion routing.
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        i_resp_s      = 1'b0;
        d_resp_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_i_s) begin
                    state_d = SERVE_I;
                    addr_d  = i_pmem_address & LINE_MASK;
                    wdata_d = d_pmem_wdata;
                end else if (d_req_s) begin
                    // Read+write together is treated as a write-back.
                    state_d = d_pmem_write ? SERVE_D_WR : SERVE_D_RD;
                    addr_d  = d_pmem_address & LINE_MASK;
                    wdata_d = d_pmem_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    i_resp_s      = 1'b1;
                    state_d       = IDLE;
                    last_served_d = REQ_I;
                end else begin
                    state_d = SERVE_I;
                end
            end
            SERVE_D_RD, SERVE_D_WR: begin
                if (pmem_resp) begin
                    d_resp_s      = 1'b1;
                    state_d       = IDLE;
                    last_served_d = REQ_D;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory strobes registered from the upcoming state.
    always_comb begin
        read_d  = 1'b0;
        write_d = 1'b0;
        case (state_d)
            SERVE_I:    read_d  = 1'b1;
            SERVE_D_RD: read_d  = 1'b1;
            SERVE_D_WR: write_d = 1'b1;
            default: begin
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // State, arbitration history, latches and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_served_q <= REQ_I;
            addr_q        <= {ADDR_W{1'b0}};
            wdata_q       <= {LINE_W{1'b0}};
            read_q        <= 1'b0;
            write_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            read_q        <= read_d;
            write_q       <= write_d;
        end
    end

    assign pmem_read    = read_q;
    assign pmem_write   = write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_pmem_resp  = i_resp_s;
    assign d_pmem_resp  = d_resp_s;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_line_arbiter.sv
// Directed bench for pmem_line_arbiter: expected grants are queued when the
// requests are driven and checked in order as the memory side sees them.
module tb_pmem_line_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    pmem_line_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    typedef struct packed {
        logic         is_i;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_WR = {4{64'h0123_4567_89AB_CDEF}};

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_i, input logic wr, input logic [31:0] addr,
                        input logic [255:0] wdata, input logic [255:0] rdata);
        exp_t e;
        e.is_i  = is_i;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Wait for a grant, check it against the queue head, answer after
    // 'delay' cycles and check the response routing and turnaround.
    task automatic serve_one(input int exp_lat, input int delay, input bit scramble);
        exp_t e;
        int   n;
        n = 0;
        while (!(pmem_read || pmem_write) && n < 20) begin
            tick();
            n++;
        end
        if (!(pmem_read || pmem_write)) begin
            total++;
            bad++;
            $error("FAIL grant_timeout observed=no_strobe expected=strobe");
            return;
        end
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL unexpected_grant observed=%0h expected=none", pmem_address);
            return;
        end
        e = sb.pop_front();
        if (exp_lat >= 0) check("grant_latency", n, exp_lat);
        check("grant_addr", pmem_address, e.addr);
        check("write_strobe", pmem_write, e.wr);
        check("read_strobe", pmem_read, !e.wr);
        if (e.wr) check("grant_wdata", pmem_wdata, e.wdata);
        if (scramble) begin
            d_pmem_wdata   = ~d_pmem_wdata;
            d_pmem_address = d_pmem_address ^ 32'h0F0F_0F00;
            i_pmem_address = i_pmem_address ^ 32'h0F0F_0F00;
        end
        repeat (delay) tick();
        check("addr_hold", pmem_address, e.addr);
        if (e.wr) check("wdata_hold", pmem_wdata, e.wdata);
        check("no_early_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
        pmem_rdata = e.rdata;
        pmem_resp  = 1'b1;
        #1;
        check("i_resp", i_pmem_resp, e.is_i);
        check("d_resp", d_pmem_resp, !e.is_i);
        if (e.is_i) check("i_rdata", i_pmem_rdata, e.rdata);
        else        check("d_rdata", d_pmem_rdata, e.rdata);
        tick();
        pmem_resp = 1'b0;
        if (e.is_i) begin
            i_pmem_read = 1'b0;
        end else begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
        end
        #1;
        check("turnaround_idle", {pmem_read, pmem_write}, 2'b00);
        check("resp_single", {i_pmem_resp, d_pmem_resp}, 2'b00);
    endtask

    initial begin
        rst_n          = 1'b0;
        i_pmem_read    = 1'b0;
        i_pmem_address = 32'h0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = 32'h0;
        d_pmem_wdata   = 256'h0;
        pmem_rdata     = 256'h0;
        pmem_resp      = 1'b0;
        #3;
        check("rst_strobes_resps", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, 4'b0000);
        check("rst_addr", pmem_address, 256'h0);
        check("rst_wdata", pmem_wdata, 256'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();

        // Contention out of reset: D first, then strict alternation.
        i_pmem_address = 32'h1000_0044;
        d_pmem_address = 32'h2000_0077;
        i_pmem_read    = 1'b1;
        d_pmem_read    = 1'b1;
        push(1'b0, 1'b0, 32'h2000_0060, 256'h0, {32{8'h11}});
        push(1'b1, 1'b0, 32'h1000_0040, 256'h0, {32{8'h22}});
        push(1'b0, 1'b0, 32'h2000_0060, 256'h0, {32{8'h33}});
        push(1'b1, 1'b0, 32'h1000_0040, 256'h0, {32{8'h44}});
        serve_one(1, 1, 1'b0);
        tick();
        d_pmem_read = 1'b1;
        serve_one(0, 1, 1'b0);
        tick();
        i_pmem_read = 1'b1;
        serve_one(0, 2, 1'b0);
        serve_one(1, 1, 1'b0);
        tick();

        // I-cache read alone.
        i_pmem_address = 32'h0000_1234;
        i_pmem_read    = 1'b1;
        push(1'b1, 1'b0, 32'h0000_1220, 256'h0, PAT_A5);
        serve_one(1, 3, 1'b0);
        tick();

        // D-cache write-back alone, inputs disturbed mid-transaction.
        d_pmem_address = 32'h8000_0040;
        d_pmem_wdata   = PAT_WR;
        d_pmem_write   = 1'b1;
        push(1'b0, 1'b1, 32'h8000_0040, PAT_WR, {32{8'h3C}});
        serve_one(1, 2, 1'b1);
        tick();

        // Illegal read+write from the D-cache is a write-back.
        d_pmem_address = 32'h0000_2FFF;
        d_pmem_wdata   = ~PAT_WR;
        d_pmem_read    = 1'b1;
        d_pmem_write   = 1'b1;
        push(1'b0, 1'b1, 32'h0000_2FE0, ~PAT_WR, {32{8'h5A}});
        serve_one(1, 1, 1'b0);
        tick();

        // Spurious memory response in IDLE.
        pmem_resp = 1'b1;
        #1;
        check("spurious_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
        tick();
        check("spurious_idle", {pmem_read, pmem_write}, 2'b00);
        pmem_resp = 1'b0;
        tick();
        check("spurious_idle2", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, 4'b0000);

        // Reset during SERVE_I abandons the transaction.
        i_pmem_address = 32'h0000_5555;
        i_pmem_read    = 1'b1;
        tick();
        check("pre_rst_strobe", pmem_read, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_read", pmem_read, 1'b0);
        pmem_resp   = 1'b1;
        i_pmem_read = 1'b0;
        #1;
        check("rst_no_resp", i_pmem_resp, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        check("post_rst_quiet", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, 4'b0000);
        pmem_resp = 1'b0;
        tick();

        // Next contention after reset goes to D.
        i_pmem_address = 32'h0000_3000;
        d_pmem_address = 32'h0000_4010;
        i_pmem_read    = 1'b1;
        d_pmem_read    = 1'b1;
        push(1'b0, 1'b0, 32'h0000_4000, 256'h0, {32{8'h66}});
        push(1'b1, 1'b0, 32'h0000_3000, 256'h0, {32{8'h77}});
        serve_one(1, 1, 1'b0);
        serve_one(1, 1, 1'b0);
        tick();

        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
